// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - shared encodings for the universal shift register
// Purpose: operation-select (mode) encodings and FSM state encodings
//          used by univ_shift_reg and usr_shifter.
// Ports:   none (package).
package usr_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_LOAD  = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_SHR   = 3'b011,
    MODE_SAR   = 3'b100,
    MODE_ROL   = 3'b101,
    MODE_ROR   = 3'b110,
    MODE_HOLD2 = 3'b111
  } usr_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BURST = 2'b01,
    ST_DONE  = 2'b10
  } usr_state_e;

endpackage

// File: rtl/usr_shifter.sv
// rtl/usr_shifter.sv - combinational shift/rotate datapath
// Purpose: computes the next register value for the shift/rotate modes.
//          HOLD, LOAD and the spare encoding return q unchanged (LOAD is
//          resolved in the top, which owns d_in).
// Ports:   q      - current register contents
//          mode   - operation select
//          amt    - shift/rotate distance
//          ser_in - fill bit for logical shifts
//          q_next - resulting value
module usr_shifter
  import usr_pkg::*;
#(
  parameter int N  = 8,
  parameter int AW = $clog2(N)
) (
  input  logic [N-1:0]  q,
  input  logic [2:0]    mode,
  input  logic [AW-1:0] amt,
  input  logic          ser_in,
  output logic [N-1:0]  q_next
);

  localparam logic [AW:0] N_W = (AW+1)'(N);

  logic [N-1:0]        ones;
  logic [N-1:0]        fill;
  logic [N-1:0]        shl_v;
  logic [N-1:0]        shr_v;
  logic signed [N-1:0] sar_v;
  logic [N-1:0]        rol_v;
  logic [N-1:0]        ror_v;
  logic [AW:0]         inv_amt;
  logic                amt_ok;

  always_comb begin
    ones    = '1;
    fill    = {N{ser_in}};
    // amt=0 makes inv_amt equal N, and a shift by the full width yields 0,
    // so the rotate degenerates cleanly to q.
    inv_amt = N_W - {1'b0, amt};
    // Only reachable for non-power-of-2 N: out-of-range distances hold.
    amt_ok  = ({1'b0, amt} < N_W);

    shl_v = (q << amt) | (fill & ~(ones << amt));
    shr_v = (q >> amt) | (fill & ~(ones >> amt));
    sar_v = $signed(q) >>> amt;
    rol_v = (q << amt) | (q >> inv_amt);
    ror_v = (q >> amt) | (q << inv_amt);

    q_next = q;
    if (amt_ok) begin
      case (mode)
        MODE_SHL: q_next = shl_v;
        MODE_SHR: q_next = shr_v;
        MODE_SAR: q_next = sar_v;
        MODE_ROL: q_next = rol_v;
        MODE_ROR: q_next = ror_v;
        default:  q_next = q;
      endcase
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with burst serialiser
// Purpose: N-bit register supporting load, logical/arithmetic shifts and
//          rotates by a variable distance, plus a start-triggered burst
//          that shifts the loaded word out LSB-first on ser_out.
// Ports:   clk, rst_n (async, active-low), en (clock enable),
//          mode, amt, d_in, ser_in, start  - controls and data
//          q, ser_out (=q[0]), busy (in BURST), done (in DONE)
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int N  = 8,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [2:0]    mode,
  input  logic [AW-1:0] amt,
  input  logic [N-1:0]  d_in,
  input  logic          ser_in,
  input  logic          start,
  output logic [N-1:0]  q,
  output logic          ser_out,
  output logic          busy,
  output logic          done
);

  localparam int          CW       = $clog2(N+1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N-1);

  usr_state_e    state_q, state_d;
  logic [N-1:0]  q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  shift_q;

  usr_shifter #(.N(N), .AW(AW)) u_shifter (
    .q      (q_q),
    .mode   (mode),
    .amt    (amt),
    .ser_in (ser_in),
    .q_next (shift_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    if (en) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            q_d     = d_in;
            cnt_d   = '0;
            state_d = ST_BURST;
          end else if (mode == MODE_LOAD) begin
            q_d = d_in;
          end else begin
            q_d = shift_q;
          end
        end
        ST_BURST: begin
          q_d = {ser_in, q_q[N-1:1]};
          // cnt_q holds the number of shifts already done; the edge that
          // sees N-1 performs the last one and the counter stops there.
          if (cnt_q == CNT_LAST) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // done is a decode of the state, so it naturally stretches while en=0.
  assign q       = q_q;
  assign ser_out = q_q[0];
  assign busy    = (state_q == ST_BURST);
  assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - self-checking bench for univ_shift_reg
module tb_univ_shift_reg;

  localparam int N  = 8;
  localparam int AW = 3;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [2:0]    mode;
  logic [AW-1:0] amt;
  logic [N-1:0]  d_in;
  logic          ser_in;
  logic          start;
  logic [N-1:0]  q;
  logic          ser_out;
  logic          busy;
  logic          done;

  int n_pass;
  int n_total;

  univ_shift_reg #(.N(N), .AW(AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .mode    (mode),
    .amt     (amt),
    .d_in    (d_in),
    .ser_in  (ser_in),
    .start   (start),
    .q       (q),
    .ser_out (ser_out),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    mode;
    logic [AW-1:0] amt;
    logic [N-1:0]  d_in;
    logic          ser_in;
    logic [N-1:0]  exp_q;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic [2:0] m, input logic [AW-1:0] a,
                         input logic [N-1:0] d, input logic s, input logic [N-1:0] e);
    vecs[i].mode   = m;
    vecs[i].amt    = a;
    vecs[i].d_in   = d;
    vecs[i].ser_in = s;
    vecs[i].exp_q  = e;
  endtask

  logic [N-1:0] exp_q;
  logic [N-1:0] burst_word;
  logic [N-1:0] q_frozen;

  initial begin
    n_pass  = 0;
    n_total = 0;

    // mode, amt, d_in, ser_in, expected q after the edge
    set_vec(0,  3'b001, 3'd0, 8'hA5, 1'b0, 8'hA5);
    set_vec(1,  3'b010, 3'd3, 8'h00, 1'b1, 8'h2F);
    set_vec(2,  3'b001, 3'd0, 8'hA5, 1'b0, 8'hA5);
    set_vec(3,  3'b011, 3'd3, 8'h00, 1'b0, 8'h14);
    set_vec(4,  3'b001, 3'd0, 8'hA5, 1'b0, 8'hA5);
    set_vec(5,  3'b100, 3'd3, 8'h00, 1'b0, 8'hF4);
    set_vec(6,  3'b001, 3'd0, 8'h81, 1'b0, 8'h81);
    set_vec(7,  3'b101, 3'd1, 8'h00, 1'b0, 8'h03);
    set_vec(8,  3'b001, 3'd0, 8'h81, 1'b0, 8'h81);
    set_vec(9,  3'b110, 3'd1, 8'h00, 1'b0, 8'hC0);
    set_vec(10, 3'b010, 3'd0, 8'h00, 1'b1, 8'hC0);
    set_vec(11, 3'b100, 3'd0, 8'h00, 1'b1, 8'hC0);
    set_vec(12, 3'b000, 3'd3, 8'h12, 1'b1, 8'hC0);
    set_vec(13, 3'b111, 3'd5, 8'h34, 1'b1, 8'hC0);
    set_vec(14, 3'b011, 3'd7, 8'h00, 1'b1, 8'hFF);
    set_vec(15, 3'b010, 3'd7, 8'h00, 1'b0, 8'h80);
    set_vec(16, 3'b101, 3'd4, 8'h00, 1'b0, 8'h08);
    set_vec(17, 3'b100, 3'd7, 8'h00, 1'b1, 8'h00);

    // Reset: asynchronous, and clock edges are ignored while low.
    rst_n  = 1'b1;
    en     = 1'b1;
    mode   = 3'b001;
    amt    = '0;
    d_in   = 8'h5A;
    ser_in = 1'b0;
    start  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_q", 32'(q), 32'h00);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    step();
    chk("reset_hold_q", 32'(q), 32'h00);
    rst_n = 1'b1;

    // Table-driven mode vectors
    for (int i = 0; i < 18; i++) begin
      mode   = vecs[i].mode;
      amt    = vecs[i].amt;
      d_in   = vecs[i].d_in;
      ser_in = vecs[i].ser_in;
      step();
      chk($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].exp_q));
      chk($sformatf("vec%0d_ser_out", i), 32'(ser_out), 32'(vecs[i].exp_q[0]));
    end

    // Burst of 0xB4 with start and mode changes while busy
    mode   = 3'b000;
    ser_in = 1'b0;
    d_in   = 8'hB4;
    start  = 1'b1;
    burst_word = 8'hB4;
    step();
    d_in = 8'h3C;
    mode = 3'b001;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("burst_busy%0d", i), 32'(busy), 32'h1);
      chk($sformatf("burst_bit%0d", i), 32'(ser_out), 32'(burst_word[i]));
      chk($sformatf("burst_nodone%0d", i), 32'(done), 32'h0);
      step();
    end
    start = 1'b0;
    chk("burst_done", 32'(done), 32'h1);
    chk("burst_busy_end", 32'(busy), 32'h0);
    chk("burst_q_done", 32'(q), 32'h00);
    mode = 3'b000;
    step();
    chk("burst_done_clear", 32'(done), 32'h0);
    chk("burst_idle_busy", 32'(busy), 32'h0);
    chk("burst_idle_q", 32'(q), 32'h00);

    // Enable freeze mid-burst, with ser_in=1 fill
    ser_in = 1'b1;
    d_in   = 8'h5A;
    start  = 1'b1;
    exp_q  = 8'h5A;
    step();
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i == 3) begin
        en = 1'b0;
        q_frozen = q;
        for (int k = 0; k < 3; k++) begin
          step();
          chk($sformatf("frz_q%0d", k), 32'(q), 32'(q_frozen));
          chk($sformatf("frz_busy%0d", k), 32'(busy), 32'h1);
        end
        en = 1'b1;
      end
      chk($sformatf("en_q%0d", i), 32'(q), 32'(exp_q));
      chk($sformatf("en_busy%0d", i), 32'(busy), 32'h1);
      exp_q = {ser_in, exp_q[N-1:1]};
      step();
    end
    chk("en_done", 32'(done), 32'h1);
    chk("en_q_final", 32'(q), 32'hFF);
    en = 1'b0;
    step();
    step();
    chk("en_done_stretch", 32'(done), 32'h1);
    en = 1'b1;
    step();
    chk("en_done_clear", 32'(done), 32'h0);

    // Reset pulsed mid-burst aborts without a done pulse
    ser_in = 1'b0;
    d_in   = 8'hC3;
    start  = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("abort_pre_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_q", 32'(q), 32'h00);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    step();
    rst_n = 1'b1;
    mode  = 3'b000;
    for (int i = 0; i < N + 2; i++) begin
      step();
      chk($sformatf("abort_nodone%0d", i), 32'(done), 32'h0);
      chk($sformatf("abort_idle%0d", i), 32'(busy), 32'h0);
    end
    mode = 3'b001;
    d_in = 8'h77;
    step();
    chk("resume_load", 32'(q), 32'h77);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 SHALL have parameter N, default 8; register width, legal N >= 2.
REQ-002 SHALL have parameter AW, default $clog2(N); shift-amount width.
REQ-003 SHALL have port clk, input, 1 bit; single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit; asynchronous reset, active-low.
REQ-005 SHALL have port en, input, 1 bit; clock enable, 0 freezes all state including FSM and counter.
REQ-006 SHALL have port mode, input, 3 bits; operation select, sampled only in IDLE.
REQ-007 SHALL have port amt, input, AW bits; shift/rotate distance 0..N-1.
REQ-008 SHALL have port d_in, input, N bits; parallel load data.
REQ-009 SHALL have port ser_in, input, 1 bit; fill value for vacated bits in logical shifts.
REQ-010 SHALL have port start, input, 1 bit; burst-serialise request.
REQ-011 SHALL have port q, output, N bits; register contents.
REQ-012 SHALL have port ser_out, output, 1 bit; equals q[0] at all times.
REQ-013 SHALL have port busy, output, 1 bit; high in BURST state.
REQ-014 SHALL have port done, output, 1 bit; single-cycle pulse at burst end.

Function
REQ-015 SHALL, in IDLE with en=1 and start=0, apply mode each cycle: 000 HOLD, 001 LOAD q<=d_in, 010 SHL, 011 SHR, 100 SAR, 101 ROL, 110 ROR, 111 HOLD.
REQ-016 SHALL perform SHL by amt with the amt vacated LSBs all set to ser_in.
REQ-017 SHALL perform SHR by amt with the amt vacated MSBs all set to ser_in.
REQ-018 SHALL perform SAR by amt with the vacated MSBs set to the old q[N-1].
REQ-019 SHALL perform ROL/ROR by amt modulo N with no bit lost.
REQ-020 SHALL treat amt=0 as no change for modes 010-110; amt values >= N (non-power-of-2 N) SHALL be treated as HOLD.
REQ-021 SHALL implement an FSM with states IDLE, BURST, DONE.
REQ-022 SHALL, on IDLE with en=1 and start=1, load q<=d_in, clear the bit counter and enter BURST next cycle; start takes priority over mode.
REQ-023 SHALL, in BURST with en=1, perform SHR by 1 with ser_in fill each cycle and increment the counter; N bits appear on ser_out LSB-first, one per cycle, the first bit during the first BURST cycle.
REQ-024 SHALL leave BURST for DONE after the N-th shift (counter reaches N-1 at the shift edge), with total BURST duration exactly N enabled cycles.
REQ-025 SHALL assert done for exactly one enabled cycle in DONE, then return to IDLE; q SHALL hold in DONE.
REQ-026 SHALL ignore start and mode while in BURST or DONE.
REQ-027 SHALL, when en=0, hold q, state, counter and done unchanged (done stretches while frozen).
REQ-028 SHALL use a counter width of $clog2(N+1) bits with no wrap beyond N-1.

Reset
REQ-029 SHALL, on rst_n=0 asynchronously, force q=0, state=IDLE, counter=0, busy=0, done=0 regardless of clk or en.
REQ-030 SHALL abort any burst on mid-operation reset with no done pulse; operation resumes from IDLE on the first edge after rst_n rises.

Structure
REQ-031 SHALL place mode encodings (MODE_HOLD..MODE_ROR) and FSM state encodings in the shared package usr_pkg.
REQ-032 SHALL implement the combinational shift/rotate datapath as one sub-module usr_shifter (parameter N, inputs q, mode, amt, ser_in; output next value); FSM and register stay in the top.

Verification
REQ-033 SHALL cover reset/load: N=8, rst_n low -> q=0x00; release, mode=001, d_in=0xA5 -> q=0xA5 next edge.
REQ-034 SHALL cover shifts: q=0xA5, amt=3 -> SHL ser_in=1 gives 0x2F; SHR ser_in=0 gives 0x14; SAR gives 0xF4.
REQ-035 SHALL cover rotates: q=0x81, amt=1 -> ROL gives 0x03; ROR gives 0xC0; amt=0 any mode -> q unchanged.
REQ-036 SHALL cover burst: start=1, d_in=0xB4 -> busy high 8 cycles, ser_out sequence 0,0,1,0,1,1,0,1, done one cycle, then IDLE; start during busy ignored.
REQ-037 SHALL cover enable/abort: en=0 for 3 cycles mid-burst -> q and counter frozen, burst still 8 enabled cycles; rst_n pulsed mid-burst -> busy=0, q=0, no done.
